sccb_config_seq: RTL
====================

Name: sccb_config_seq

Overview:
Sequencer that programs the camera sensor's registers at power-up through the existing SCCB/I2C byte-write driver. It walks an external register table of (sub-address, data) pairs and issues one driver write per entry. Between transactions it resets the driver, retries NACKed writes, honours in-table delay markers, and reports done or error to the top level. It sits between the camera top level and the I2C driver and owns the driver's reset, wr_en, addr and data lines.

Parameters:
IDX_W, 8, width of table index
NUM_ENTRIES, 73, number of table entries processed (0..NUM_ENTRIES-1)
MAX_RETRY, 3, retries per entry after the first attempt
GAP_CYCLES, 16, idle cycles between consecutive driver transactions
TIMEOUT_CYCLES, 4096, cycles to wait for work_done before declaring failure
DELAY_UNIT, 1024, cycles per count of a delay marker
IGNORE_ACK, 0, 1 = treat every completed transaction as success

Ports:
clk  in  1  system clock (driver SCL derives from the same clock)
rst  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE/DONE/ERROR, starts a table walk
busy  out  1  high from start acceptance until DONE/ERROR
done  out  1  high in DONE until next start or reset
error  out  1  high in ERROR until next start or reset
err_index  out  IDX_W  index of the failed entry, valid while error=1
tbl_index  out  IDX_W  current table index (combinational ROM address)
tbl_addr  in  8  register sub-address at tbl_index
tbl_data  in  8  register value at tbl_index
drv_rst_n  out  1  active-low reset to the driver
drv_wr_en  out  1  one-cycle write request to the driver
drv_addr  out  8  sub-address to the driver, stable from LOAD until the next LOAD
drv_data  out  8  data byte to the driver, stable with drv_addr
drv_work_done  in  1  driver done flag; completion = rising edge
drv_ack  in  1  driver ack; 1 = all ack slots sampled high (NACK)

Behaviour:
- Reset values: busy=0, done=0, error=0, err_index=0, tbl_index=0, drv_rst_n=0, drv_wr_en=0, drv_addr=0, drv_data=0. Internal state is IDLE, retry=0, all counters=0, done_prev=0.
- drv_rst_n=0 in IDLE/DONE/ERROR/RSTDRV and 1 in all other states. The driver's request latch is sticky, so it must be reset before every transaction.
- IDLE/DONE/ERROR: on start=1, set index=0, retry=0, done=0, error=0, busy=1, then go to LOAD. start is ignored in every other state.
- LOAD (1 cycle):
  - index==NUM_ENTRIES: go to DONE.
  - tbl_addr==8'hFF (delay marker): load the delay counter with tbl_data*DELAY_UNIT (width ≥ 8+log2(DELAY_UNIT)), then go to DELAY. tbl_data=0 gives a zero-length delay: go to DELAY and leave it the next cycle.
  - Otherwise: register tbl_addr/tbl_data into drv_addr/drv_data, then go to RSTDRV.
- RSTDRV (1 cycle): drv_rst_n=0, then go to START.
- START (1 cycle): drv_wr_en=1, clear the timeout counter, then go to WAIT.
- WAIT:
  - done_prev is the registered drv_work_done.
  - Completion = drv_work_done=1 && done_prev=0. On completion, capture fail = drv_ack && !IGNORE_ACK, then go to CHECK.
  - The timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no completion, set fail=1 and go to CHECK.
  - Completion wins if both occur in the same cycle.
- CHECK (1 cycle):
  - !fail: index++, retry=0, go to GAP.
  - fail and retry<MAX_RETRY: retry++, index unchanged, go to GAP.
  - fail and retry==MAX_RETRY: err_index=index, go to ERROR.
- GAP: count GAP_CYCLES cycles (GAP_CYCLES=0 means 1 cycle), then go to LOAD.
- DELAY: count down to 0; on 0, index++, retry=0, go to LOAD. No bus activity.
- DONE: busy=0, done=1. ERROR: busy=0, error=1. Both states keep drv_rst_n=0.
- tbl_index = index at all times. index never exceeds NUM_ENTRIES.
- Asynchronous reset mid-transaction returns the block to IDLE immediately. drv_rst_n=0 therefore aborts the driver in the same event.
- Per-entry attempts = 1+MAX_RETRY.

Test Plan:
- 3-entry table {(12,80),(11,01),(3A,04)}, model acks OK, start pulse → three drv_wr_en pulses with drv_addr 12/11/3A and drv_data 80/01/04; each preceded by a 1-cycle drv_rst_n low; ≥GAP_CYCLES between pulses; done=1, busy=0 after entry 2.
- Entry 1 NACKs twice then ACKs → entry 1 issued 3 times; done=1, error=0.
- Entry 1 always NACKs, MAX_RETRY=3 → exactly 4 attempts; error=1, err_index=1; entry 2 never issued; drv_rst_n=0.
- Driver never raises work_done → after each TIMEOUT_CYCLES wait the entry is retried; error=1 after 4 timeouts, err_index=0.
- Table {(FF,02),(12,80)}, DELAY_UNIT=1024 → no drv_wr_en for 2048 cycles after the first LOAD, then one write to 0x12.
- Assert rst low in WAIT, then release, then start again → outputs return to reset values; the walk restarts from index 0 and completes normally; start pulses while busy have no effect.

Source files
------------

// File: rtl/sccb_config_seq.sv
// Power-up register sequencer for the camera sensor: walks a (sub-address, data)
// table and issues one SCCB byte write per entry with retry, timeout and delay markers.
module sccb_config_seq #(
  parameter int IDX_W          = 8,
  parameter int NUM_ENTRIES    = 73,
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DELAY_UNIT     = 1024,
  parameter int IGNORE_ACK     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [IDX_W-1:0] tbl_index,
  input  logic [7:0]       tbl_addr,
  input  logic [7:0]       tbl_data,
  output logic             drv_rst_n,
  output logic             drv_wr_en,
  output logic [7:0]       drv_addr,
  output logic [7:0]       drv_data,
  input  logic             drv_work_done,
  input  logic             drv_ack
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;
  localparam int DLY_W = 8 + $clog2(DELAY_UNIT) + 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DLY_W-1:0] DLY_UNIT = DLY_W'(DELAY_UNIT);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_ENTRIES);
  localparam logic             IGN_ACK  = (IGNORE_ACK != 0);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_RSTDRV = 4'd2,
    ST_START  = 4'd3,
    ST_WAIT   = 4'd4,
    ST_CHECK  = 4'd5,
    ST_GAP    = 4'd6,
    ST_DELAY  = 4'd7,
    ST_DONE   = 4'd8,
    ST_ERROR  = 4'd9
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] index_r;
  logic [RTY_W-1:0] retry_r;
  logic [TMO_W-1:0] tmo_r;
  logic [GAP_W-1:0] gap_r;
  logic [DLY_W-1:0] dly_r;
  logic             fail_r;
  logic             done_prev_r;
  logic             compl_s;

  assign tbl_index = index_r;
  assign compl_s   = drv_work_done & ~done_prev_r;

  // Sequencer FSM; drv_rst_n and drv_wr_en are set on the transition into the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      index_r     <= '0;
      retry_r     <= '0;
      tmo_r       <= '0;
      gap_r       <= '0;
      dly_r       <= '0;
      fail_r      <= 1'b0;
      done_prev_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_index   <= '0;
      drv_rst_n   <= 1'b0;
      drv_wr_en   <= 1'b0;
      drv_addr    <= 8'h00;
      drv_data    <= 8'h00;
    end else begin
      done_prev_r <= drv_work_done;
      drv_wr_en   <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            index_r   <= '0;
            retry_r   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            drv_rst_n <= 1'b1;
            state_r   <= ST_LOAD;
          end else begin
            drv_rst_n <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (index_r == IDX_END) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            drv_rst_n <= 1'b0;
            state_r   <= ST_DONE;
          end else if (tbl_addr == 8'hFF) begin
            dly_r   <= DLY_W'(tbl_data) * DLY_UNIT;
            state_r <= ST_DELAY;
          end else begin
            drv_addr  <= tbl_addr;
            drv_data  <= tbl_data;
            drv_rst_n <= 1'b0;
            state_r   <= ST_RSTDRV;
          end
        end
        ST_RSTDRV: begin
          drv_rst_n <= 1'b1;
          drv_wr_en <= 1'b1;
          state_r   <= ST_START;
        end
        ST_START: begin
          tmo_r   <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion edge in the final timeout cycle still counts as a real result.
          if (compl_s) begin
            fail_r  <= drv_ack & ~IGN_ACK;
            state_r <= ST_CHECK;
          end else if (tmo_r == TMO_LAST) begin
            fail_r  <= 1'b1;
            state_r <= ST_CHECK;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        ST_CHECK: begin
          gap_r <= '0;
          if (!fail_r) begin
            index_r <= index_r + IDX_W'(1);
            retry_r <= '0;
            state_r <= ST_GAP;
          end else if (retry_r < RTY_MAX) begin
            retry_r <= retry_r + RTY_W'(1);
            state_r <= ST_GAP;
          end else begin
            err_index <= index_r;
            error     <= 1'b1;
            busy      <= 1'b0;
            drv_rst_n <= 1'b0;
            state_r   <= ST_ERROR;
          end
        end
        ST_GAP: begin
          if (gap_r >= GAP_LAST) begin
            state_r <= ST_LOAD;
          end else begin
            gap_r <= gap_r + GAP_W'(1);
          end
        end
        ST_DELAY: begin
          if (dly_r == '0) begin
            index_r <= index_r + IDX_W'(1);
            retry_r <= '0;
            state_r <= ST_LOAD;
          end else begin
            dly_r <= dly_r - DLY_W'(1);
          end
        end
        default: begin
          busy      <= 1'b0;
          drv_rst_n <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
